// File: rtl/imem_pipe.sv
// imem_pipe: pipelined RV32I instruction memory with a valid/ready fetch port,
// fault flagging, flush and a word-wide program-load port.
module imem_pipe #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] FAULT_WORD  = 32'h0000_0013,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_data_o,
  output logic              rsp_misalign_o,
  output logic              rsp_oob_o,
  input  logic              flush_i,
  input  logic              load_en_i,
  input  logic [AW-1:0]     load_addr_i,
  input  logic [31:0]       load_data_i,
  output logic [15:0]       fault_cnt_o
);

  localparam int L = LATENCY;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [L-1:0]      vld;
  logic [L-1:0]      mis;
  logic [L-1:0]      oob;
  logic [31:0]       dat [L];
  logic [15:0]       fault_cnt_q;

  logic [ADDR_W-1:0] off;
  logic [AW-1:0]     req_idx;
  logic              req_mis;
  logic              req_oob;
  logic [31:0]       req_word;
  logic              stall;
  logic              adv;
  logic              accept;
  logic              fault_inc;

  // Offset wraps modulo 2^ADDR_W, so addresses below BASE_ADDR land out of range.
  assign off      = req_addr_i - ADDR_W'(BASE_ADDR);
  assign req_idx  = off[AW+1:2];
  assign req_mis  = |off[1:0];
  assign req_oob  = |off[ADDR_W-1:AW+2];
  assign req_word = (req_mis || req_oob) ? FAULT_WORD : mem[req_idx];

  assign stall       = rsp_valid_o && !rsp_ready_i;
  assign adv         = !stall || flush_i;
  assign req_ready_o = !load_en_i && adv;
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (load_en_i) mem[load_addr_i] <= load_data_i;
  end

  // Data registers only load when a valid entry moves in, so outputs hold
  // their last delivered value while the pipe is empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld <= '0;
      mis <= '0;
      oob <= '0;
      for (int k = 0; k < L; k++) dat[k] <= '0;
    end else if (adv) begin
      vld[0] <= accept;
      if (accept) begin
        dat[0] <= req_word;
        mis[0] <= req_mis;
        oob[0] <= req_oob;
      end
      for (int k = 1; k < L; k++) begin
        vld[k] <= vld[k-1] && !flush_i;
        if (vld[k-1] && !flush_i) begin
          dat[k] <= dat[k-1];
          mis[k] <= mis[k-1];
          oob[k] <= oob[k-1];
        end
      end
    end
  end

  assign rsp_valid_o    = vld[L-1];
  assign rsp_data_o     = dat[L-1];
  assign rsp_misalign_o = mis[L-1];
  assign rsp_oob_o      = oob[L-1];

  // A flush at the handshake edge discards the response, so it is not counted.
  assign fault_inc = rsp_valid_o && rsp_ready_i && !flush_i &&
                     (rsp_misalign_o || rsp_oob_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_cnt_q <= '0;
    end else if (fault_inc && (fault_cnt_q != 16'hFFFF)) begin
      fault_cnt_q <= fault_cnt_q + 16'd1;
    end
  end

  assign fault_cnt_o = fault_cnt_q;

endmodule

// File: tb/tb_imem_pipe.sv
// Bench for imem_pipe: four instances (latency 1/2/3, and latency 1 with a
// non-zero base) checked against a queue scoreboard plus directed probes.
module tb_imem_pipe;

  localparam int NI = 4;
  localparam int          LATS  [NI] = '{1, 2, 3, 1};
  localparam logic [31:0] BASES [NI] = '{32'h0, 32'h0, 32'h0, 32'h10};

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        oob;
    int          acc_cyc;
    int          acc_stall;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NI-1:0]   req_valid;
  logic [31:0]     req_addr;
  logic            rsp_ready;
  logic            flush;
  logic            load_en;
  logic [5:0]      load_addr;
  logic [31:0]     load_data;

  logic [NI-1:0]   req_ready;
  logic [NI-1:0]   rsp_valid;
  logic [NI-1:0]   rsp_mis;
  logic [NI-1:0]   rsp_oob;
  logic [31:0]     rsp_data  [NI];
  logic [15:0]     fault_cnt [NI];

  exp_t            sb [NI][$];
  logic [31:0]     mem_m [64];
  int              fcnt_m    [NI];
  int              stall_cnt [NI];
  int              popped    [NI];
  logic [NI-1:0]   prev_hold;
  logic [31:0]     prev_data [NI];
  logic [NI-1:0]   prev_mis;
  logic [NI-1:0]   prev_oob;
  logic [NI-1:0]   acc;
  int              cyc;
  int              vectors;
  int              miscompares;
  int              p0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    imem_pipe #(
      .DEPTH_WORDS (64),
      .ADDR_W      (32),
      .LATENCY     (LATS[g]),
      .BASE_ADDR   (BASES[g]),
      .INIT_FILE   (""),
      .FAULT_WORD  (32'h0000_0013)
    ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_valid_i    (req_valid[g]),
      .req_ready_o    (req_ready[g]),
      .req_addr_i     (req_addr),
      .rsp_valid_o    (rsp_valid[g]),
      .rsp_ready_i    (rsp_ready),
      .rsp_data_o     (rsp_data[g]),
      .rsp_misalign_o (rsp_mis[g]),
      .rsp_oob_o      (rsp_oob[g]),
      .flush_i        (flush),
      .load_en_i      (load_en),
      .load_addr_i    (load_addr),
      .load_data_i    (load_data),
      .fault_cnt_o    (fault_cnt[g])
    );
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t predict(int i, logic [31:0] a);
    exp_t        e;
    logic [31:0] off;
    logic [31:0] w;
    off   = a - BASES[i];
    w     = off >> 2;
    e.mis = (off[1:0] != 2'b00);
    e.oob = (w >= 32'd64);
    e.data = (e.mis || e.oob) ? 32'h0000_0013 : mem_m[w[5:0]];
    e.acc_cyc   = 0;
    e.acc_stall = 0;
    return e;
  endfunction

  // Runs at the falling edge and predicts what the next rising edge does.
  task automatic monitor();
    exp_t e;
    logic stall;
    cyc++;
    acc = '0;
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        stall = rsp_valid[i] && !rsp_ready;
        chk($sformatf("fault_cnt[%0d]", i), fault_cnt[i], fcnt_m[i]);
        chk($sformatf("req_ready[%0d]", i), req_ready[i], !load_en && (!stall || flush));
        if (prev_hold[i]) begin
          chk($sformatf("hold_valid[%0d]", i), rsp_valid[i], 1);
          chk($sformatf("hold_data[%0d]", i), rsp_data[i], prev_data[i]);
          chk($sformatf("hold_flags[%0d]", i), {rsp_mis[i], rsp_oob[i]}, {prev_mis[i], prev_oob[i]});
        end
        if (flush) begin
          sb[i].delete();
        end else if (rsp_valid[i] && rsp_ready) begin
          if (sb[i].size() == 0) begin
            chk($sformatf("spurious_rsp[%0d]", i), rsp_valid[i], 0);
          end else begin
            e = sb[i].pop_front();
            chk($sformatf("rsp_data[%0d]", i), rsp_data[i], e.data);
            chk($sformatf("rsp_mis[%0d]", i), rsp_mis[i], e.mis);
            chk($sformatf("rsp_oob[%0d]", i), rsp_oob[i], e.oob);
            chk($sformatf("latency[%0d]", i), cyc - e.acc_cyc,
                LATS[i] + stall_cnt[i] - e.acc_stall);
            popped[i]++;
            if ((e.mis || e.oob) && fcnt_m[i] < 65535) fcnt_m[i]++;
          end
        end
        prev_hold[i] = stall && !flush;
        prev_data[i] = rsp_data[i];
        prev_mis[i]  = rsp_mis[i];
        prev_oob[i]  = rsp_oob[i];
        if (stall && !flush) stall_cnt[i]++;
        if (req_valid[i] && req_ready[i]) begin
          acc[i] = 1'b1;
          e = predict(i, req_addr);
          e.acc_cyc   = cyc;
          e.acc_stall = stall_cnt[i];
          sb[i].push_back(e);
        end
      end
      if (load_en) mem_m[load_addr] = load_data;
    end else begin
      prev_hold = '0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(int i, logic [31:0] a);
    req_valid[i] = 1'b1;
    req_addr     = a;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (acc[i]) break;
    end
    vectors++;
    assert (acc[i] === 1'b1)
    else begin
      miscompares++;
      $error("FAIL accept_timeout[%0d]: req_ready observed %b expected 1", i, req_ready[i]);
    end
  endtask

  task automatic load(int a, logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a[5:0];
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    rst_n = 1'b0; req_valid = '0; req_addr = '0; rsp_ready = 1'b1;
    flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    prev_hold = '0; prev_mis = '0; prev_oob = '0;
    for (int i = 0; i < NI; i++) begin
      fcnt_m[i] = 0; stall_cnt[i] = 0; popped[i] = 0; prev_data[i] = '0;
    end
    drain(2);
    for (int i = 0; i < NI; i++) begin
      chk("rst_valid", rsp_valid[i], 0);
      chk("rst_data", rsp_data[i], 0);
      chk("rst_flags", {rsp_mis[i], rsp_oob[i]}, 0);
      chk("rst_fcnt", fault_cnt[i], 0);
      chk("rst_ready", req_ready[i], 1);
    end
    rst_n = 1'b1;
    tick();

    load(0, 32'h0050_0113); load(1, 32'h00C0_0193);
    load(2, 32'hFF71_8393); load(3, 32'h0023_E233);
    load(4, 32'h00A0_0513); load(5, 32'h00B0_0593);
    load(6, 32'h40B5_0633); load(7, 32'h00C0_2023);

    // Sequential fetch, latency 1
    send(0, 32'h0);
    chk("seq_first_valid", rsp_valid[0], 1);
    chk("seq_first_data", rsp_data[0], 32'h0050_0113);
    send(0, 32'h4); send(0, 32'h8); send(0, 32'hC);
    req_valid[0] = 1'b0;
    drain(4);
    chk("seq_count", popped[0], 4);
    chk("seq_fcnt", fault_cnt[0], 0);

    // Backpressure, latency 3
    p0 = popped[2];
    send(2, 32'h0); send(2, 32'h4); send(2, 32'h8);
    chk("bp_first_valid", rsp_valid[2], 1);
    rsp_ready = 1'b0;
    req_addr  = 32'hC;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_ready_low", req_ready[2], 0);
      chk("bp_data_held", rsp_data[2], 32'h0050_0113);
    end
    rsp_ready = 1'b1;
    send(2, 32'hC); send(2, 32'h10); send(2, 32'h14);
    req_valid[2] = 1'b0;
    drain(8);
    chk("bp_count", popped[2] - p0, 6);

    // Faults
    send(0, 32'h2);
    chk("mis_data", rsp_data[0], 32'h0000_0013);
    chk("mis_flags", {rsp_mis[0], rsp_oob[0]}, 2'b10);
    send(0, 32'h100);
    chk("oob_flags", {rsp_mis[0], rsp_oob[0]}, 2'b01);
    send(0, 32'hFFFF_FFFC);
    chk("oob_wrap0", rsp_oob[0], 1);
    req_valid[0] = 1'b0;
    drain(3);
    chk("fcnt_three", fault_cnt[0], 3);
    send(3, 32'hFFFF_FFFC);
    chk("base_wrap_flags", {rsp_mis[3], rsp_oob[3]}, 2'b01);
    send(3, 32'h14);
    chk("base_data", rsp_data[3], 32'h00C0_0193);
    req_valid[3] = 1'b0;
    drain(3);
    force g_dut[0].dut.fault_cnt_q = 16'hFFFE;
    fcnt_m[0] = 65534;
    #1 release g_dut[0].dut.fault_cnt_q;
    tick();
    chk("fcnt_preset", fault_cnt[0], 16'hFFFE);
    send(0, 32'h2); send(0, 32'h6); send(0, 32'h200);
    req_valid[0] = 1'b0;
    drain(3);
    chk("fcnt_sat", fault_cnt[0], 16'hFFFF);

    // Flush, latency 2
    send(1, 32'h0); send(1, 32'h4);
    flush = 1'b1;
    send(1, 32'h8);
    flush = 1'b0;
    req_valid[1] = 1'b0;
    chk("flush_kill", rsp_valid[1], 0);
    tick();
    chk("flush_next_valid", rsp_valid[1], 1);
    chk("flush_next_data", rsp_data[1], 32'hFF71_8393);
    drain(3);

    // Load hazard, latency 3
    send(2, 32'h4);
    req_valid[2] = 1'b0;
    load(1, 32'hDEAD_BEEF);
    drain(5);
    chk("hazard_old_word", rsp_data[2], 32'h00C0_0193);
    send(0, 32'h4);
    chk("hazard_new_word", rsp_data[0], 32'hDEAD_BEEF);
    req_valid[0] = 1'b0;
    drain(2);

    // Asynchronous reset with requests in flight
    send(2, 32'h0); send(2, 32'h4); send(2, 32'h8);
    req_valid[2] = 1'b0;
    chk("pre_reset_valid", rsp_valid[2], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", rsp_valid[2], 0);
    chk("arst_data", rsp_data[2], 0);
    chk("arst_fcnt", fault_cnt[0], 0);
    chk("arst_ready", req_ready[2], 1);
    for (int i = 0; i < NI; i++) begin
      sb[i].delete();
      fcnt_m[i] = 0;
    end
    drain(2);
    rst_n = 1'b1;
    drain(6);
    chk("post_reset_quiet", rsp_valid[2], 0);
    send(2, 32'h4);
    req_valid[2] = 1'b0;
    drain(4);
    chk("post_reset_mem", rsp_data[2], 32'hDEAD_BEEF);
    send(0, 32'h4);
    chk("post_reset_mem0", rsp_data[0], 32'hDEAD_BEEF);
    req_valid[0] = 1'b0;
    drain(2);

    for (int i = 0; i < NI; i++) chk($sformatf("leftover[%0d]", i), sb[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
